// File: rtl/instr_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode and execute T-states driving the CPU datapath strobes.
// Define SEQ_ICOUNT_EN to add the retired-instruction counter output instr_count.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int NUM_REGS    = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run_i,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                memRead,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [4:0]          alu_op,
    output logic                running,
    output logic                illegal,
    output logic                bus_error
`ifdef SEQ_ICOUNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_unary, is_nop, is_halt;
    logic       unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_nop    = (opcode == OP_NOP);
    assign is_halt   = (opcode == OP_HALT);

    assign timeout_hit = (wait_cnt == CW'(MEM_TIMEOUT - 1));

    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
        reg_sel = NUM_REGS'(1) << idx;
    endfunction

    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            // wait_cnt counts completed T1 cycles without mem_ready; zero on every T1 entry
            if (state == T1 && !mem_ready && !timeout_hit)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
            if (state == T1 && !mem_ready && timeout_hit)
                bus_error <= 1'b1;
        end
    end

`ifdef SEQ_ICOUNT_EN
    always_ff @(posedge clock) begin
        if (!clear)
            instr_count <= '0;
        else if (state_next == T0 && (state == T3 || state == T5 || state == T6))
            instr_count <= instr_count + 32'd1;
    end
`endif

    always_comb begin
        state_next = state;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        memRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        alu_op     = 5'b00000;
        illegal    = 1'b0;
        running    = 1'b0;

        case (state)
            IDLE: begin
                if (run_i)
                    state_next = T0;
            end
            T0: begin
                running    = 1'b1;
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                state_next = T1;
            end
            T1: begin
                running = 1'b1;
                memRead = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready)
                    state_next = T2;
                else if (timeout_hit)
                    state_next = HALTED;
            end
            T2: begin
                running    = 1'b1;
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = T3;
            end
            T3: begin
                running = 1'b1;
                if (is_alu || is_muldiv) begin
                    Rout       = reg_sel(rb);
                    Yin        = 1'b1;
                    state_next = T4;
                end else if (is_unary) begin
                    state_next = T4;
                end else if (is_nop) begin
                    state_next = T0;
                end else if (is_halt) begin
                    state_next = HALTED;
                end else begin
                    illegal    = 1'b1;
                    state_next = T0;
                end
            end
            T4: begin
                running = 1'b1;
                alu_op  = opcode;
                Zin     = 1'b1;
                // operand source differs: binary ops read Rc, unary Rb, MUL/DIV Ra
                if (is_alu)
                    Rout = reg_sel(rc);
                else if (is_unary)
                    Rout = reg_sel(rb);
                else if (is_muldiv)
                    Rout = reg_sel(ra);
                state_next = T5;
            end
            T5: begin
                running = 1'b1;
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    state_next = T6;
                end else begin
                    Rin        = reg_sel(ra);
                    state_next = T0;
                end
            end
            T6: begin
                running    = 1'b1;
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                state_next = T0;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: every cycle of each instruction is compared
// against hand-derived strobe/register/alu_op values.
module tb_instr_sequencer;

    localparam logic [12:0] PCOUT    = 13'h1000;
    localparam logic [12:0] INCPC    = 13'h0800;
    localparam logic [12:0] MARIN    = 13'h0400;
    localparam logic [12:0] MEMREAD  = 13'h0200;
    localparam logic [12:0] MDRIN    = 13'h0100;
    localparam logic [12:0] MDROUT   = 13'h0080;
    localparam logic [12:0] IRIN     = 13'h0040;
    localparam logic [12:0] YIN      = 13'h0020;
    localparam logic [12:0] ZIN      = 13'h0010;
    localparam logic [12:0] ZHIGHOUT = 13'h0008;
    localparam logic [12:0] ZLOWOUT  = 13'h0004;
    localparam logic [12:0] HIIN     = 13'h0002;
    localparam logic [12:0] LOIN     = 13'h0001;

    localparam logic [31:0] IR_AND  = 32'h5091_8000;
    localparam logic [31:0] IR_ADD  = 32'h1A2B_0000;
    localparam logic [31:0] IR_MUL  = 32'h7B38_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    // NEG with Ra=R0 and Rb=R15 exercises both ends of the register select
    localparam logic [31:0] IR_NEG  = {5'b10001, 4'd0, 4'd15, 4'd0, 15'd0};

    logic        clock = 1'b0;
    logic        clear;
    logic        run_i;
    logic        mem_ready;
    logic [31:0] ir;
    logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        running, illegal, bus_error;
`ifdef SEQ_ICOUNT_EN
    logic [31:0] instr_count;
`endif

    int checks   = 0;
    int failures = 0;

    instr_sequencer #(.MEM_TIMEOUT(255), .NUM_REGS(16)) dut (
        .clock(clock), .clear(clear), .run_i(run_i), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .running(running), .illegal(illegal), .bus_error(bus_error)
`ifdef SEQ_ICOUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clock = ~clock;

    logic [52:0] obs_vec;
    assign obs_vec = {PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
                      Zhighout, Zlowout, HIin, LOin, running, illegal, bus_error,
                      Rin, Rout, alu_op};

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [12:0] strb, input logic run,
                              input logic ill, input logic berr, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] op);
        checkOutput(tag, 64'(obs_vec), 64'({strb, run, ill, berr, rin, rout, op}));
    endtask

    task automatic applyStimulus(input logic clr, input logic run, input logic mrdy,
                                 input logic [31:0] instr);
        clear     = clr;
        run_i     = run;
        mem_ready = mrdy;
        ir        = instr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks T0, T1 (single cycle, mem_ready=1), T2; returns one cycle into T3
    task automatic doFetch(input string tag);
        checkCycle({tag, "_t0"}, PCOUT | MARIN | INCPC, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle({tag, "_t1"}, MEMREAD | MDRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle({tag, "_t2"}, MDROUT | IRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
    endtask

    initial begin
        applyStimulus(0, 0, 1, IR_AND);
        tick();
        tick();
        checkCycle("reset", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
`ifdef SEQ_ICOUNT_EN
        checkOutput("reset_count", 64'(instr_count), 64'd0);
`endif

        // AND R1,R2,R3; run_i dropped after start must not matter
        applyStimulus(1, 1, 1, IR_AND);
        tick();
        run_i = 1'b0;
        doFetch("and");
        checkCycle("and_t3", YIN, 1, 0, 0, 16'h0, 16'h0004, 5'd0);
        tick();
        checkCycle("and_t4", ZIN, 1, 0, 0, 16'h0, 16'h0008, 5'b01010);
        tick();
        checkCycle("and_t5", ZLOWOUT, 1, 0, 0, 16'h0002, 16'h0, 5'd0);
        tick();
`ifdef SEQ_ICOUNT_EN
        checkOutput("and_count", 64'(instr_count), 64'd1);
`endif

        // ADD R4,R5,R6 with memory ready on the third T1 cycle
        applyStimulus(1, 0, 0, IR_ADD);
        checkCycle("add_t0", PCOUT | MARIN | INCPC, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkCycle($sformatf("add_t1_%0d", i), MEMREAD | MDRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        end
        mem_ready = 1'b1;
        tick();
        checkCycle("add_t2", MDROUT | IRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle("add_t3", YIN, 1, 0, 0, 16'h0, 16'h0020, 5'd0);
        tick();
        checkCycle("add_t4", ZIN, 1, 0, 0, 16'h0, 16'h0040, 5'b00011);
        tick();
        checkCycle("add_t5", ZLOWOUT, 1, 0, 0, 16'h0010, 16'h0, 5'd0);
        tick();

        // MUL R6,R7
        ir = IR_MUL;
        doFetch("mul");
        checkCycle("mul_t3", YIN, 1, 0, 0, 16'h0, 16'h0080, 5'd0);
        tick();
        checkCycle("mul_t4", ZIN, 1, 0, 0, 16'h0, 16'h0040, 5'b01111);
        tick();
        checkCycle("mul_t5", ZLOWOUT | LOIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle("mul_t6", ZHIGHOUT | HIIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();

        // NEG R0,R15
        ir = IR_NEG;
        doFetch("neg");
        checkCycle("neg_t3", 13'h0, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle("neg_t4", ZIN, 1, 0, 0, 16'h0, 16'h8000, 5'b10001);
        tick();
        checkCycle("neg_t5", ZLOWOUT, 1, 0, 0, 16'h0001, 16'h0, 5'd0);
        tick();

        ir = IR_NOP;
        doFetch("nop");
        checkCycle("nop_t3", 13'h0, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();

        ir = IR_ILL;
        doFetch("ill");
        checkCycle("ill_t3", 13'h0, 1, 1, 0, 16'h0, 16'h0, 5'd0);
        tick();
`ifdef SEQ_ICOUNT_EN
        checkOutput("ill_count", 64'(instr_count), 64'd6);
`endif

        ir = IR_HALT;
        doFetch("halt");
        checkCycle("halt_t3", 13'h0, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        run_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkCycle($sformatf("halted_%0d", i), 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
            tick();
        end

        // Memory timeout: 255 T1 cycles then HALTED with sticky bus_error
        applyStimulus(0, 0, 0, IR_AND);
        tick();
        checkCycle("to_reset", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
        applyStimulus(1, 1, 0, IR_AND);
        tick();
        checkCycle("to_t0", PCOUT | MARIN | INCPC, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle("to_t1_first", MEMREAD | MDRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        for (int i = 2; i <= 255; i++) tick();
        checkCycle("to_t1_last", MEMREAD | MDRIN, 1, 0, 0, 16'h0, 16'h0, 5'd0);
        tick();
        checkCycle("to_halted", 13'h0, 0, 0, 1, 16'h0, 16'h0, 5'd0);
        tick();
        tick();
        checkCycle("to_sticky", 13'h0, 0, 0, 1, 16'h0, 16'h0, 5'd0);
        clear = 1'b0;
        tick();
        checkCycle("to_cleared", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
        applyStimulus(1, 0, 1, IR_AND);
        tick();
        checkCycle("to_idle", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
        run_i = 1'b1;
        tick();

        // Reset in the middle of T4
        run_i = 1'b0;
        doFetch("rst");
        checkCycle("rst_t3", YIN, 1, 0, 0, 16'h0, 16'h0004, 5'd0);
        tick();
        checkCycle("rst_t4", ZIN, 1, 0, 0, 16'h0, 16'h0008, 5'b01010);
        clear = 1'b0;
        tick();
        checkCycle("rst_abort", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);
`ifdef SEQ_ICOUNT_EN
        checkOutput("rst_count", 64'(instr_count), 64'd0);
`endif
        clear = 1'b1;
        tick();
        checkCycle("rst_idle", 13'h0, 0, 0, 0, 16'h0, 16'h0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hardwired control unit that replaces hand-driven T-state stimulus with an automatic control sequence.
- Runs instruction fetch (T0-T2), then decodes the IR and drives the CPU datapath strobes for register-register ALU, unary, MUL/DIV and HALT instructions.
- Sits beside the CPU datapath; its outputs connect one-for-one to the datapath control inputs.

Parameters:
- MEM_TIMEOUT, 255, max cycles spent waiting for mem_ready in T1 before bus_error.
- NUM_REGS, 16, general registers; sets width of Rin/Rout.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-low reset.
- run_i  in  1  start/resume request.
- mem_ready  in  1  memory read data valid on mDataIn.
- ir  in  32  current IR contents from datapath.
- PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes.
- Rin  out  NUM_REGS  one-hot register write enable.
- Rout  out  NUM_REGS  one-hot register bus drive.
- alu_op  out  5  ALU operation; equals ir[31:27] during T4, else 0.
- running  out  1  sequencer active.
- illegal  out  1  one-cycle pulse on unknown opcode.
- bus_error  out  1  sticky memory timeout flag.

Behaviour:
- IR fields: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- Opcodes: ADD 00011, SUB 00100, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011. All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
- All outputs are decoded from the state register and ir only. Each strobe is high for exactly one full clock cycle.
- Reset (clear=0 at a rising edge): state=IDLE; all strobes, Rin, Rout, alu_op, illegal, bus_error and running are 0. Reset mid-instruction aborts immediately.
- IDLE: running=0. run_i=1 -> T0.
- T0: PCout, MARin, IncPC. -> T1.
- T1: memRead, MDRin held high while waiting.
  - mem_ready=1 -> T2.
  - Wait counter reaches MEM_TIMEOUT -> bus_error=1, state=HALTED.
  - mem_ready already 1 on entry gives a single T1 cycle.
- T2: MDRout, IRin. -> T3.
- T3 (decode uses ir loaded at end of T2):
  - ALU ops and MUL/DIV: Rout[Rb], Yin. -> T4.
  - NEG/NOT: no strobes. -> T4.
  - NOP: -> T0.
  - HALT: -> HALTED.
  - Illegal: illegal=1, -> T0.
- T4:
  - ALU ops: Rout[Rc], Zin, alu_op.
  - NEG/NOT: Rout[Rb], Zin, alu_op.
  - MUL/DIV: Rout[Ra], Zin, alu_op.
  - -> T5.
- T5:
  - ALU/unary: Zlowout, Rin[Ra]. -> T0.
  - MUL/DIV: Zlowout, LOin. -> T6.
- T6 (MUL/DIV only): Zhighout, HIin. -> T0.
- HALTED: running=0; bus_error holds. Exit only via reset.
- running=1 in T0..T6.
- run_i is sampled only in IDLE; deassertion mid-instruction is ignored.
- Latency: ALU/unary instruction takes 6 cycles plus extra T1 wait cycles; MUL/DIV takes 7 plus wait cycles.
- Rin and Rout are never both nonzero in the same cycle. At most one bit of each is set.
- Register fields select all 16 registers, including R0.

Optional Feature:
- Macro name: SEQ_ICOUNT_EN.
- Defined: adds output port instr_count[31:0].
  - Cleared by reset.
  - Increments on each transition back to T0 from T3, T5 or T6 (NOP and illegal included).
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- AND: reset, run_i=1, mem_ready tied 1, ir=32'h5091_8000 -> T3 Rout=16'h0004+Yin; T4 Rout=16'h0008+Zin, alu_op=5'b01010; T5 Rin=16'h0002+Zlowout; back in T0 six cycles after the first T0.
- ADD with 3-cycle memory wait: ir=32'h1A2B_0000, mem_ready high on 3rd T1 cycle -> memRead/MDRin high 3 cycles; T3 Rout[5], T4 Rout[6] with alu_op=5'b00011, T5 Rin[4]; total 8 cycles.
- MUL: ir=32'h7B38_0000 -> T3 Rout[7]+Yin; T4 Rout[6]+Zin, alu_op=5'b01111; T5 Zlowout+LOin; T6 Zhighout+HIin; Rin stays 0 throughout.
- HALT/illegal: ir=32'hF800_0000 -> illegal pulses 1 cycle in T3, next state T0; then ir=32'hD800_0000 -> HALTED, running=0, run_i=1 ignored.
- Timeout: mem_ready held 0 -> bus_error=1 after 255 T1 cycles, state HALTED; clear=0 for one edge -> all outputs 0, state IDLE.
- Reset mid-T4 of AND -> next cycle all strobes 0, IDLE; with SEQ_ICOUNT_EN, instr_count=0.
